// File: rtl/lcd_timing_pkg.sv
// Shared timing defaults, RGB565 field layout and reader FSM encoding for the LCD frame-buffer reader.
// Pure definitions: no latency, no flow control.
package lcd_timing_pkg;

  localparam int DEF_H_ACT  = 480;
  localparam int DEF_H_SYNC = 41;
  localparam int DEF_H_BP   = 2;
  localparam int DEF_H_FP   = 2;
  localparam int DEF_V_ACT  = 272;
  localparam int DEF_V_SYNC = 10;
  localparam int DEF_V_BP   = 2;
  localparam int DEF_V_FP   = 2;
  localparam int DEF_H_TOT  = DEF_H_SYNC + DEF_H_BP + DEF_H_ACT + DEF_H_FP;
  localparam int DEF_V_TOT  = DEF_V_SYNC + DEF_V_BP + DEF_V_ACT + DEF_V_FP;
  localparam int DEF_ADDR_W = 17;

  // Wide enough for H_TOT=525 and V_TOT=286 with headroom.
  localparam int CNT_W = 11;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } state_e;

  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic de;
    logic rd;
  } ctl_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb_t;

  function automatic rgb_t unpack565(input logic [15:0] d);
    rgb_t p;
    p.r = d[R_MSB:R_LSB];
    p.g = d[G_MSB:G_LSB];
    p.b = d[B_MSB:B_LSB];
    return p;
  endfunction

endpackage

// File: rtl/lcd_timing_gen.sv
// Raster counters with combinational sync/DE decode and frame-start strobe for the current position.
// Zero latency relative to the counters; free-running, never stalls.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_ACT  = DEF_H_ACT,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int H_FP   = DEF_H_FP,
  parameter int V_ACT  = DEF_V_ACT,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP,
  parameter int V_FP   = DEF_V_FP
) (
  input  logic iClk,
  input  logic iRst,
  output logic hsync_n_o,
  output logic vsync_n_o,
  output logic de_o,
  output logic frame_start_o
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_B  = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_ACT_E  = CNT_W'(H_SYNC + H_BP + H_ACT);
  localparam logic [CNT_W-1:0] V_ACT_B  = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_ACT_E  = CNT_W'(V_SYNC + V_BP + V_ACT);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + CNT_ONE;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign hsync_n_o = (h_cnt_q >= H_SYNC_E);
  assign vsync_n_o = (v_cnt_q >= V_SYNC_E);
  assign de_o      = (h_cnt_q >= H_ACT_B) && (h_cnt_q < H_ACT_E) &&
                     (v_cnt_q >= V_ACT_B) && (v_cnt_q < V_ACT_E);
  // Held off during reset so the first post-release clock carries the only pulse.
  assign frame_start_o = ~iRst && (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/lcd_buf_rd.sv
// LCD-side ping-pong frame-buffer reader: raster timing, bank choice per frame, RGB565 fetch and unpack.
// Read strobe 1 clock after the counters, pixels/sync/DE 3 clocks after; panel timing never stalls.
module lcd_buf_rd
  import lcd_timing_pkg::*;
#(
  parameter int H_ACT  = DEF_H_ACT,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int H_FP   = DEF_H_FP,
  parameter int V_ACT  = DEF_V_ACT,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP,
  parameter int V_FP   = DEF_V_FP,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              buf0_full_wr_i,
  input  logic              buf1_full_wr_i,
  output logic              ram_rd_en_o,
  output logic              ram_rd_buf_o,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  input  logic [15:0]       ram_rd_data_i,
  output logic              lcd_hsync_o,
  output logic              lcd_vsync_o,
  output logic              lcd_de_o,
  output logic [4:0]        lcd_r_o,
  output logic [5:0]        lcd_g_o,
  output logic [4:0]        lcd_b_o,
  output logic              frame_start_o
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam ctl_t CTL_RST = '{hsync_n: 1'b1, vsync_n: 1'b1, de: 1'b0, rd: 1'b0};

  logic tg_hsync_n, tg_vsync_n, tg_de, tg_fs;

  lcd_timing_gen #(
    .H_ACT (H_ACT),  .H_SYNC(H_SYNC), .H_BP(H_BP), .H_FP(H_FP),
    .V_ACT (V_ACT),  .V_SYNC(V_SYNC), .V_BP(V_BP), .V_FP(V_FP)
  ) u_timing (
    .iClk         (iClk),
    .iRst         (iRst),
    .hsync_n_o    (tg_hsync_n),
    .vsync_n_o    (tg_vsync_n),
    .de_o         (tg_de),
    .frame_start_o(tg_fs)
  );

  state_e            state_q;
  logic              bank_q;
  logic [ADDR_W-1:0] pix_q, pix_d, addr_q;
  ctl_t              s1_q, s1_d, s2_q;
  rgb_t              rgb_q, rgb_d;
  logic              hsync_q, vsync_q, de_q;

  // Mode and bank only move at frame start, so a displayed frame never mixes banks.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_BLANK;
      bank_q  <= 1'b0;
    end else if (tg_fs) begin
      if (buf0_full_wr_i || buf1_full_wr_i) state_q <= S_SHOW;
      if (buf0_full_wr_i)      bank_q <= 1'b0;
      else if (buf1_full_wr_i) bank_q <= 1'b1;
    end
  end

  always_comb begin
    s1_d  = '{hsync_n: tg_hsync_n, vsync_n: tg_vsync_n, de: tg_de,
              rd: tg_de && (state_q == S_SHOW)};
    pix_d = pix_q;
    if (tg_fs)        pix_d = '0;
    else if (s1_d.rd) pix_d = pix_q + ADDR_ONE;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      s1_q   <= CTL_RST;
      s2_q   <= CTL_RST;
      pix_q  <= '0;
      addr_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s1_q;
      pix_q <= pix_d;
      if (s1_d.rd) addr_q <= pix_q;
    end
  end

  // Stage 2 sees the RAM word for the read issued in stage 1.
  always_comb begin
    rgb_d = '0;
    if (s2_q.rd) rgb_d = unpack565(ram_rd_data_i);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hsync_q <= s2_q.hsync_n;
      vsync_q <= s2_q.vsync_n;
      de_q    <= s2_q.de;
      rgb_q   <= rgb_d;
    end
  end

  assign ram_rd_en_o   = s1_q.rd;
  assign ram_rd_buf_o  = bank_q;
  assign ram_rd_addr_o = addr_q;
  assign lcd_hsync_o   = hsync_q;
  assign lcd_vsync_o   = vsync_q;
  assign lcd_de_o      = de_q;
  assign lcd_r_o       = rgb_q.r;
  assign lcd_g_o       = rgb_q.g;
  assign lcd_b_o       = rgb_q.b;
  assign frame_start_o = tg_fs;

endmodule

// File: doc/lcd_buf_rd.md
# lcd_buf_rd

Display-side reader of the camera ping-pong frame buffer. It generates 480x272 RGB-LCD timing and fetches RGB565 pixels from whichever buffer the camera writer most recently completed. It drives the panel pins directly. It sits downstream of the camera buffer writer and shares the dual-bank RAM with it; the writer owns the write port and this block owns the read port.

## Interface
- H_ACT, 480, active pixels per line
- H_SYNC / H_BP / H_FP, 41 / 2 / 2, horizontal sync, back-porch and front-porch widths in clocks
- V_ACT, 272, active lines per frame
- V_SYNC / V_BP / V_FP, 10 / 2 / 2, vertical sync, back-porch and front-porch widths in lines
- ADDR_W, 17, RAM word-address width
- iClk  in  1  pixel clock; sole clock, also the RAM read clock
- iRst  in  1  reset, asynchronous, active-high
- buf0_full_wr_i  in  1  level from writer; 1 means bank 0 holds the newest complete frame
- buf1_full_wr_i  in  1  level from writer; 1 means bank 1 holds the newest complete frame
- ram_rd_en_o  out  1  read strobe
- ram_rd_buf_o  out  1  bank being read
- ram_rd_addr_o  out  ADDR_W  word address inside the bank
- ram_rd_data_i  in  16  RGB565 word; valid exactly 1 clock after ram_rd_en_o is sampled
- lcd_hsync_o, lcd_vsync_o  out  1  sync outputs, active-low
- lcd_de_o  out  1  data enable
- lcd_r_o / lcd_g_o / lcd_b_o  out  5/6/5  pixel colour
- frame_start_o  out  1  one-clock pulse at each frame start (h=0, v=0)

## Operation
- Counters:
  - h_cnt runs 0..H_TOT-1, where H_TOT = H_SYNC+H_BP+H_ACT+H_FP (525).
  - v_cnt runs 0..V_TOT-1, where V_TOT = V_SYNC+V_BP+V_ACT+V_FP (286). v_cnt increments when h_cnt wraps.
  - Region order inside each period: sync, back porch, active, front porch.
- Active region:
  - h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT-1] and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT-1].
- FSM, two states:
  - S_BLANK is entered on reset. Timing runs, lcd_de_o toggles normally, colour is forced to 0, and no reads are issued.
  - At frame start, if either full flag is 1, go to S_SHOW. Otherwise stay in S_BLANK.
  - S_SHOW is held until reset.
- Bank selection at every frame start:
  - buf0_full_wr_i=1 selects bank 0. Otherwise buf1_full_wr_i=1 selects bank 1.
  - If both flags are 0, the previous selection is kept.
  - If both flags are 1 (illegal), bank 0 is selected.
  - The selected bank is held in ram_rd_buf_o for the entire frame. Flag changes mid-frame are ignored until the next frame start (no tearing).
  - If the writer has not finished a new frame, the same bank is re-displayed.
- Address counter:
  - Cleared at frame start.
  - Increments by 1 after each issued read, so the address equals line*H_ACT + pixel.
  - The last address is H_ACT*V_ACT-1 = 130559, which fits 17 bits with no wrap.
- Pixel unpack: r = data[15:11], g = data[10:5], b = data[4:0].
- Outside the active region, or in S_BLANK, colour outputs are 0.

## Timing
- Pipeline, with the counters at position X in cycle T:
  - ram_rd_en_o and ram_rd_addr_o are registered and valid in cycle T+1.
  - ram_rd_data_i is valid in cycle T+2.
  - lcd_* outputs are registered and valid in cycle T+3.
- Sync and DE are delayed through 3 register stages so they stay aligned with the colour data.
- ram_rd_en_o leads lcd_de_o by exactly 2 clocks.
- frame_start_o is aligned with the counter stage (cycle T); it is not delayed.
- Reset values:
  - lcd_hsync_o = 1 and lcd_vsync_o = 1.
  - lcd_de_o = 0, all colour outputs = 0, frame_start_o = 0.
  - ram_rd_en_o = 0, ram_rd_addr_o = 0, ram_rd_buf_o = 0.
  - Counters = 0, state = S_BLANK.
- Assertion of iRst mid-frame takes effect immediately. After release, the first clock is frame start (h=0, v=0).
- lcd_hsync_o is low for H_SYNC clocks per line. lcd_vsync_o is low for V_SYNC full lines.
- Per frame there are exactly H_ACT*V_ACT read strobes and the same number of DE-high clocks.

## Structure
- Package lcd_timing_pkg holds:
  - the default timing constants and derived H_TOT / V_TOT;
  - RGB565 field positions;
  - the FSM state encoding.
- Sub-module lcd_timing_gen contains the counters, region decode, undelayed sync/DE/active and frame_start.
- The top level contains the FSM, bank latch, address counter, 3-stage alignment pipeline and unpack logic.

## Test plan
- Reset, then run 2 frames with both flags at 0:
  - sync periods are 525 clocks per line and 286 lines per frame;
  - 130560 DE-high clocks per frame;
  - colour is always 0 and ram_rd_en_o is never 1.
- Hold buf0_full_wr_i=1 before the frame start, with a RAM model returning data = address[15:0]:
  - ram_rd_buf_o = 0;
  - the first DE pixel is 0x0000 and the second is r=0, g=0, b=1;
  - the last read address is 130559.
- Flags swap from buf0 to buf1 during line 100:
  - ram_rd_buf_o stays 0 until the next frame_start_o;
  - it then reads 1 for the whole following frame.
- Alignment check, with a RAM model returning 0xF800:
  - lcd_de_o rises exactly 2 clocks after the first ram_rd_en_o;
  - lcd_r_o = 31 while DE=1, and all colour outputs are 0 while DE=0.
- Assert iRst at v=150, h=300 for 3 clocks:
  - all outputs return to reset values during reset;
  - after release, frame_start_o pulses on the first clock and the address restarts at 0.
- Both flags forced to 1: bank 0 is selected.
